// File: rtl/control_collector_layer1.sv
// Sink-side collector for the layer-1 pipeline: row-major writes of one frame per start.
// Optional RELU_EN macro clamps negative result words to zero on the write path.
module control_collector_layer1 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 224,
  parameter int unsigned IMG_H  = 224,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] pixel_count
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic              wr_en_d, busy_d, done_d, overrun_d;
  logic [ADDR_W-1:0] wr_addr_d, pixel_count_d;
  logic [DATA_W-1:0] wr_data_d, data_fmt;

  // Write-path formatting; with ReLU fused, negative words become zero.
`ifdef RELU_EN
  assign data_fmt = data_in[DATA_W-1] ? '0 : data_in;
`else
  assign data_fmt = data_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      lin_q       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      pixel_count <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lin_q       <= lin_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      busy        <= busy_d;
      done        <= done_d;
      overrun     <= overrun_d;
      pixel_count <= pixel_count_d;
    end
  end

  // Next-state and registered-output values; the linear address is a plain counter.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    lin_d         = lin_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    done_d        = 1'b0;
    overrun_d     = overrun;
    pixel_count_d = pixel_count;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = COLLECT;
          col_d         = '0;
          row_d         = '0;
          lin_d         = '0;
          pixel_count_d = '0;
          overrun_d     = 1'b0;
        end
        // A stray valid wins over the clear from a coincident start.
        if (valid_in) overrun_d = 1'b1;
      end
      COLLECT: begin
        if (valid_in) begin
          wr_en_d       = 1'b1;
          wr_addr_d     = lin_q;
          wr_data_d     = data_fmt;
          pixel_count_d = pixel_count + ADDR_W'(1);
          lin_d         = lin_q + ADDR_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (valid_in) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COLLECT);
  end

endmodule

// File: tb/tb_control_collector_layer1.sv
// Self-checking bench for control_collector_layer1 on a 4x3 frame; scoreboard plus vector table.
// Build with or without RELU_EN; the vector table selects matching expected write data.
module tb_control_collector_layer1;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int NPIX = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_en, busy, done, overrun;
  logic [AW-1:0] wr_addr, pixel_count;
  logic [DW-1:0] wr_data;

  control_collector_layer1 #(.DATA_W(DW), .IMG_W(4), .IMG_H(3), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overrun(overrun), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] pc;
  } exp_t;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NPIX];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d);
    start = s;
    valid_in = v;
    data_in = d;
    tick();
    start = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic begin_frame();
    idx = 0;
    drive(1'b1, 1'b0, '0);
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input logic [DW-1:0] e);
    exp_t x;
    x.addr = AW'(idx);
    x.data = e;
    x.last = (idx == NPIX - 1);
    x.pc   = AW'(idx + 1);
    sb.push_back(x);
    idx++;
    drive(1'b0, 1'b1, d);
  endtask

  task automatic end_frame(input string name, input int exp_done);
    tick();
    tick();
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pixel_count"}, 32'(pixel_count), 32'(NPIX));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_overrun"}, 32'(overrun), 32'd0);
    check({name, "_pixel_count"}, 32'(pixel_count), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{16'hFFFD, 16'hFFFD};
    vecs[1]  = '{16'd5,    16'd5};
    vecs[2]  = '{16'h8000, 16'h8000};
    vecs[3]  = '{16'd0,    16'd0};
    vecs[4]  = '{16'd7,    16'd7};
    vecs[5]  = '{16'hFFFF, 16'hFFFF};
    vecs[6]  = '{16'd100,  16'd100};
    vecs[7]  = '{16'hFF9C, 16'hFF9C};
    vecs[8]  = '{16'h7FFF, 16'h7FFF};
    vecs[9]  = '{16'hFFFE, 16'hFFFE};
    vecs[10] = '{16'd1,    16'd1};
    vecs[11] = '{16'd2,    16'd2};
`ifdef RELU_EN
    foreach (vecs[i]) if (vecs[i].din[DW-1]) vecs[i].exp = '0;
`endif

    // Output monitor: every write must match the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (done) done_cnt++;
          if (wr_en) begin
            if (sb.size() == 0) begin
              check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
              exp_t x;
              x = sb.pop_front();
              check("wr_addr", 32'(wr_addr), 32'(x.addr));
              check("wr_data", 32'(wr_data), 32'(x.data));
              check("done_with_write", 32'(done), 32'(x.last));
              check("busy_during_write", 32'(busy), 32'(!x.last));
              check("pixel_count", 32'(pixel_count), 32'(x.pc));
            end
          end else if (done) begin
            check("done_without_write", 32'(done), 32'd0);
          end
        end
      end
    join_none

    // 1: reset state, then a back-to-back frame
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    begin_frame();
    check("s1_busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < NPIX; i++) send_pixel(DW'(i + 1), DW'(i + 1));
    end_frame("s1", 1);
    check("s1_overrun", 32'(overrun), 32'd0);

    // 2: random idle gaps, with an ignored start mid-frame
    begin_frame();
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(DW'(i + 1), DW'(i + 1));
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, DW'($urandom));
      if (i == 5) begin
        drive(1'b1, 1'b0, '0);
        check("s2_start_ignored_busy", 32'(busy), 32'd1);
      end
    end
    end_frame("s2", 2);
    check("s2_overrun", 32'(overrun), 32'd0);

    // 3: stray valid in IDLE sets overrun; next start clears it
    drive(1'b0, 1'b1, 16'd55);
    tick();
    check("s3_overrun_set", 32'(overrun), 32'd1);
    begin_frame();
    check("s3_overrun_cleared", 32'(overrun), 32'd0);
    for (int i = 0; i < NPIX; i++) send_pixel(DW'(20 + i), DW'(20 + i));
    end_frame("s3", 3);
    check("s3_overrun_end", 32'(overrun), 32'd0);

    // 4: start with coincident valid; that valid is dropped and flagged
    idx = 0;
    drive(1'b1, 1'b1, 16'd99);
    check("s4_overrun", 32'(overrun), 32'd1);
    check("s4_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NPIX; i++) send_pixel(DW'(40 + i), DW'(40 + i));
    end_frame("s4", 4);
    check("s4_overrun_sticky", 32'(overrun), 32'd1);

    // 5: asynchronous reset after five pixels, then a clean frame
    begin_frame();
    for (int i = 0; i < 5; i++) send_pixel(DW'(60 + i), DW'(60 + i));
    @(negedge clk);
    #1;
    check("s5_sb_before_rst", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    #1;
    check_all_zero("s5_async_rst");
    #2;
    rst = 1'b0;
    sb.delete();
    check("s5_no_done_on_abort", 32'(done_cnt), 32'd4);
    begin_frame();
    for (int i = 0; i < NPIX; i++) send_pixel(DW'(80 + i), DW'(80 + i));
    end_frame("s5", 5);

    // 6: signed data table through the write path, then DONE-state corner cases
    begin_frame();
    for (int i = 0; i < NPIX - 1; i++) send_pixel(vecs[i].din, vecs[i].exp);
    send_pixel(vecs[NPIX-1].din, vecs[NPIX-1].exp);
    drive(1'b1, 1'b1, 16'd77);
    check("s6_overrun_in_done", 32'(overrun), 32'd1);
    check("s6_busy_in_idle", 32'(busy), 32'd0);
    tick();
    check("s6_start_in_done_ignored", 32'(busy), 32'd0);
    check("s6_pixel_count_held", 32'(pixel_count), 32'(NPIX));
    check("s6_sb_empty", 32'(sb.size()), 32'd0);
    check("s6_done_cnt", 32'(done_cnt), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
